d_mem_dump_uart: RTL and testbench
==================================

Name: d_mem_dump_uart

Overview:
- Debug consumer that sits directly downstream of the mips core's data-memory debug read port.
- On a start pulse it walks a configurable word range by driving the core's debug_address input.
- It captures each word from debug_data and serialises it on a UART TX line (8N1, raw binary, most significant byte first).
- Lets a host dump data memory after a program runs, without touching the processor datapath.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- START_ADDR, 32'h0000_0000, byte address of the first word dumped; must be a multiple of 4.
- WORD_COUNT, 16, number of 32-bit words per dump; legal range 0..65535.

Ports:
- clk  in  1  system clock, shared with the mips core.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  single-cycle request to begin a dump; sampled on the rising edge of clk.
- debug_address  out  32  byte address presented to the core's debug read port.
- debug_data  in  32  combinational read data returned for debug_address.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high from the cycle after an accepted start until the last stop bit completes.
- done  out  1  one-cycle pulse when a dump finishes.

Behaviour:
- Reset (rst=0, async):
  - Outputs: tx=1, busy=0, done=0, debug_address=START_ADDR.
  - Internals: state IDLE; baud counter, bit index, byte index and word counter all cleared.
  - Reset mid-frame aborts the dump immediately; tx returns high in the same cycle rst falls, and no partial frame resumes after rst is released.
- Shared register: debug_address is registered; debug_data is sampled one full cycle after debug_address changes.
- States: IDLE, SETUP, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT_BYTE, NEXT_WORD, FINISH.
- IDLE:
  - start=1 with WORD_COUNT>0 -> SETUP, busy=1.
  - start=1 with WORD_COUNT=0 -> FINISH.
  - start while busy is ignored; it is neither queued nor restarts the dump.
- SETUP (1 cycle): debug_address holds the current word address -> LOAD.
- LOAD (1 cycle): capture debug_data into a 32-bit shift word, byte index=0 -> START_BIT.
- START_BIT: tx=0 for exactly CLKS_PER_BIT cycles -> DATA_BITS.
- DATA_BITS:
  - 8 bits, LSB first, of the current byte; each bit held exactly CLKS_PER_BIT cycles.
  - Byte order within a word: [31:24], [23:16], [15:8], [7:0].
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles.
  - byte index<3 -> NEXT_BYTE.
  - Else -> NEXT_WORD.
- NEXT_BYTE (1 cycle): select the next byte -> START_BIT.
  - This gives 1 extra idle-high cycle between bytes.
- NEXT_WORD (1 cycle): increment the word counter; debug_address += 4, modulo 2^32.
  - Counter == WORD_COUNT -> FINISH.
  - Else -> SETUP.
- FINISH (1 cycle): done=1, busy=0 -> IDLE; debug_address reloads START_ADDR.
- Captured data: later changes on debug_data (e.g. core writes) do not affect bytes already in flight.
- Arithmetic:
  - Baud counter is 16-bit; it counts 0..CLKS_PER_BIT-1, and its terminal count advances the bit.
  - Word counter is 16-bit; address wrap at 32'hFFFF_FFFC -> 32'h0000_0000 is legal and is not an error.
- Frame length per word: 4*(10*CLKS_PER_BIT) + 3 NEXT_BYTE cycles + SETUP + LOAD + NEXT_WORD.

Decomposition:
- Shared package mips_debug_pkg holds:
  - the state enum;
  - UART_DATA_BITS=8 and BYTES_PER_WORD=4;
  - the byte-select ordering constant.
- One natural sub-module: uart_tx_byte, containing the baud counter, start/data/stop sequencing and a one-cycle byte_done strobe.
  - Its interface is a load/byte/busy handshake.
  - The top level owns the address walk, word capture and byte sequencing.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and a behavioural memory model returning debug_data = address ^ 32'hA5A5_0000.
- Single word (WORD_COUNT=1, START_ADDR=0x10, start pulse):
  - tx emits bytes A5, A5, 00, 10, each frame 40 cycles, LSB first with start=0 and stop=1.
  - done pulses once; busy lasts 166 cycles.
- Multi-word (WORD_COUNT=3, START_ADDR=0x0):
  - debug_address sequence is 0x0, 0x4, 0x8; 12 bytes are emitted.
  - debug_address returns to 0x0 after FINISH.
- Start while busy (second start pulse 50 cycles into a dump): ignored; byte count and done timing are identical to a single dump.
- Mid-frame reset (rst=0 during DATA_BITS of byte 2):
  - tx=1 and busy=0 immediately.
  - After release, no further edges appear on tx until a new start.
- Address wrap (START_ADDR=0xFFFF_FFF8, WORD_COUNT=3): addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, with correct data for each.
- Empty dump (WORD_COUNT=0, start pulse):
  - No start bit ever appears on tx.
  - done pulses exactly 1 cycle after start is sampled; busy never rises.

Source files
------------

// File: rtl/d_mem_dump_uart_pkg.sv
// Shared constants, state encodings and byte-lane helper for the data-memory
// UART dump block and its byte serialiser.
package mips_debug_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;

  // Lane picked for byte index i lives in bits [2*i+1:2*i]; index 0 is lane 3 (MSB first)
  localparam logic [7:0] BYTE_LANE_ORDER = {2'd0, 2'd1, 2'd2, 2'd3};

  typedef logic [3:0] dump_state_t;

  localparam dump_state_t ST_IDLE      = 4'd0;
  localparam dump_state_t ST_SETUP     = 4'd1;
  localparam dump_state_t ST_LOAD      = 4'd2;
  localparam dump_state_t ST_START_BIT = 4'd3;
  localparam dump_state_t ST_DATA_BITS = 4'd4;
  localparam dump_state_t ST_STOP_BIT  = 4'd5;
  localparam dump_state_t ST_NEXT_BYTE = 4'd6;
  localparam dump_state_t ST_NEXT_WORD = 4'd7;
  localparam dump_state_t ST_FINISH    = 4'd8;

  typedef logic [1:0] tx_phase_t;

  localparam tx_phase_t TX_IDLE  = 2'd0;
  localparam tx_phase_t TX_START = 2'd1;
  localparam tx_phase_t TX_DATA  = 2'd2;
  localparam tx_phase_t TX_STOP  = 2'd3;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] lane;
    lane = BYTE_LANE_ORDER[{idx, 1'b0} +: 2];
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/d_mem_dump_uart_if.sv
// Debug read port between the mips core data memory and the dump block.
interface d_mem_dump_uart_if;

  logic [31:0] debug_address;
  logic [31:0] debug_data;

  modport master (output debug_address, input debug_data);
  modport slave  (input debug_address, output debug_data);

endinterface

// File: rtl/d_mem_dump_uart_tx_byte.sv
// 8N1 serialiser for one byte: start bit, eight data bits LSB first, stop bit,
// with a combinational strobe on the last cycle of the stop bit.
module uart_tx_byte
  import mips_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_tx,
  output logic       o_bit_tick,
  output logic       o_last_bit,
  output logic       o_byte_done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_phase_t   r_phase;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_tick;

  assign w_tick      = (r_phase != TX_IDLE) && (r_baud == BAUD_LAST);
  assign o_busy      = (r_phase != TX_IDLE);
  assign o_tx        = r_tx;
  assign o_bit_tick  = w_tick;
  assign o_last_bit  = (r_phase == TX_DATA) && (r_bit == BIT_LAST);
  assign o_byte_done = w_tick && (r_phase == TX_STOP);

  // Bit sequencing; r_tx is the registered line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= TX_IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_phase)
        TX_IDLE: begin
          if (i_load) begin
            r_phase <= TX_START;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= i_byte;
            r_tx    <= 1'b0;
          end else begin
            r_tx    <= 1'b1;
          end
        end
        TX_START: begin
          if (w_tick) begin
            r_phase <= TX_DATA;
            r_baud  <= 16'd0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud  <= r_baud + 16'd1;
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            r_baud <= 16'd0;
            if (r_bit == BIT_LAST) begin
              r_phase <= TX_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            r_phase <= TX_IDLE;
            r_baud  <= 16'd0;
          end else begin
            r_baud  <= r_baud + 16'd1;
          end
        end
        default: begin
          r_phase <= TX_IDLE;
          r_baud  <= 16'd0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/d_mem_dump_uart.sv
// Walks a word range on the core's debug read port and streams each word
// out of a UART TX line, most significant byte first.
module d_mem_dump_uart
  import mips_debug_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] START_ADDR   = 32'h0000_0000,
  parameter int          WORD_COUNT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  d_mem_dump_uart_if.master   dbg,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  localparam logic [15:0] WORD_TOTAL = 16'(WORD_COUNT);
  localparam logic [1:0]  BYTE_LAST  = 2'(BYTES_PER_WORD - 1);

  dump_state_t r_state;
  dump_state_t w_next_state;
  logic [31:0] r_addr;
  logic [31:0] r_word;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_word_cnt;
  logic        r_busy;
  logic        r_done;

  logic        w_load;
  logic [7:0]  w_load_byte;
  logic        w_tx;
  logic        w_tx_busy;
  logic        w_bit_tick;
  logic        w_last_bit;
  logic        w_byte_done;

  assign dbg.debug_address = r_addr;
  assign tx   = w_tx;
  assign busy = r_busy;
  assign done = r_done;

  // First byte comes straight off the read port since r_word is captured on the same edge
  always_comb begin
    w_load      = 1'b0;
    w_load_byte = 8'd0;
    if (r_state == ST_LOAD) begin
      w_load      = !w_tx_busy;
      w_load_byte = word_byte(dbg.debug_data, 2'd0);
    end else if (r_state == ST_NEXT_BYTE) begin
      w_load      = !w_tx_busy;
      w_load_byte = word_byte(r_word, r_byte_idx + 2'd1);
    end else begin
      w_load      = 1'b0;
      w_load_byte = 8'd0;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (WORD_COUNT == 0) ? ST_FINISH : ST_SETUP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SETUP:     w_next_state = ST_LOAD;
      ST_LOAD:      w_next_state = ST_START_BIT;
      ST_START_BIT: begin
        if (w_bit_tick) begin
          w_next_state = ST_DATA_BITS;
        end else begin
          w_next_state = ST_START_BIT;
        end
      end
      ST_DATA_BITS: begin
        if (w_bit_tick && w_last_bit) begin
          w_next_state = ST_STOP_BIT;
        end else begin
          w_next_state = ST_DATA_BITS;
        end
      end
      ST_STOP_BIT: begin
        if (w_byte_done) begin
          w_next_state = (r_byte_idx == BYTE_LAST) ? ST_NEXT_WORD : ST_NEXT_BYTE;
        end else begin
          w_next_state = ST_STOP_BIT;
        end
      end
      ST_NEXT_BYTE: w_next_state = ST_START_BIT;
      ST_NEXT_WORD: begin
        if ((r_word_cnt + 16'd1) == WORD_TOTAL) begin
          w_next_state = ST_FINISH;
        end else begin
          w_next_state = ST_SETUP;
        end
      end
      ST_FINISH:    w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // State, address walk, word capture and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= START_ADDR;
      r_word     <= 32'd0;
      r_byte_idx <= 2'd0;
      r_word_cnt <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE) && (w_next_state != ST_FINISH);
      r_done  <= (w_next_state == ST_FINISH);
      case (r_state)
        ST_LOAD: begin
          r_word     <= dbg.debug_data;
          r_byte_idx <= 2'd0;
        end
        ST_NEXT_BYTE: begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end
        ST_NEXT_WORD: begin
          r_word_cnt <= r_word_cnt + 16'd1;
          r_addr     <= r_addr + 32'd4;
        end
        ST_FINISH: begin
          r_word_cnt <= 16'd0;
          r_addr     <= START_ADDR;
        end
        default: begin
          r_byte_idx <= r_byte_idx;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_byte      (w_load_byte),
    .o_busy      (w_tx_busy),
    .o_tx        (w_tx),
    .o_bit_tick  (w_bit_tick),
    .o_last_bit  (w_last_bit),
    .o_byte_done (w_byte_done)
  );

endmodule

// File: tb/tb_d_mem_dump_uart.sv
// Scoreboard bench: four dump instances with different ranges share clock and
// reset; a UART receiver decodes the selected tx line against queued bytes.
`timescale 1ns/1ps
module tb_d_mem_dump_uart;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic [3:0]  tx_w;
  logic [3:0]  busy_w;
  logic [3:0]  done_w;
  logic [31:0] addr_w [4];
  logic [1:0]  sel;
  logic        tx_sel, busy_sel, done_sel;
  logic [31:0] addr_sel;

  int cyc       = 0;
  int tx_edges  = 0;
  int busy_cnt  = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  logic tx_prev = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];

  always #5 clk = ~clk;

  d_mem_dump_uart_if if0 ();
  d_mem_dump_uart_if if1 ();
  d_mem_dump_uart_if if2 ();
  d_mem_dump_uart_if if3 ();

  assign if0.debug_data = if0.debug_address ^ 32'hA5A5_0000;
  assign if1.debug_data = if1.debug_address ^ 32'hA5A5_0000;
  assign if2.debug_data = if2.debug_address ^ 32'hA5A5_0000;
  assign if3.debug_data = if3.debug_address ^ 32'hA5A5_0000;
  assign addr_w[0] = if0.debug_address;
  assign addr_w[1] = if1.debug_address;
  assign addr_w[2] = if2.debug_address;
  assign addr_w[3] = if3.debug_address;

  d_mem_dump_uart #(.CLKS_PER_BIT(CPB), .START_ADDR(32'h0000_0010), .WORD_COUNT(1)) u_one (
    .clk(clk), .rst(rst), .start(start_v[0]), .dbg(if0),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  d_mem_dump_uart #(.CLKS_PER_BIT(CPB), .START_ADDR(32'h0000_0000), .WORD_COUNT(3)) u_multi (
    .clk(clk), .rst(rst), .start(start_v[1]), .dbg(if1),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  d_mem_dump_uart #(.CLKS_PER_BIT(CPB), .START_ADDR(32'hFFFF_FFF8), .WORD_COUNT(3)) u_wrap (
    .clk(clk), .rst(rst), .start(start_v[2]), .dbg(if2),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  d_mem_dump_uart #(.CLKS_PER_BIT(CPB), .START_ADDR(32'h0000_0000), .WORD_COUNT(0)) u_empty (
    .clk(clk), .rst(rst), .start(start_v[3]), .dbg(if3),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  assign tx_sel   = tx_w[sel];
  assign busy_sel = busy_w[sel];
  assign done_sel = done_w[sel];
  assign addr_sel = addr_w[sel];

  always @(posedge clk) cyc <= cyc + 1;

  // Activity counters on the selected instance, sampled mid-cycle
  always @(negedge clk) begin
    tx_prev <= tx_sel;
    if (tx_prev != tx_sel) tx_edges <= tx_edges + 1;
    if (busy_sel) busy_cnt <= busy_cnt + 1;
    if (done_sel) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] addr);
    logic [31:0] w;
    w = addr ^ 32'hA5A5_0000;
    exp_addr_q.push_back(addr);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic pulse_start(input int idx, output int s);
    start_v[idx] = 1'b1;
    s = cyc;
    step(1);
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_tx_low(output logic ok);
    int waited;
    waited = 0;
    while (tx_sel !== 1'b0 && waited < 2000) begin
      step(1);
      waited++;
    end
    ok = (tx_sel === 1'b0);
    if (!ok) check_val("rx_timeout", {31'd0, tx_sel}, 32'd0);
  endtask

  task automatic recv_bytes(input int n);
    int t0, t_prev;
    logic ok;
    logic [7:0] b, e;
    t_prev = 0;
    for (int k = 0; k < n; k++) begin
      wait_tx_low(ok);
      if (!ok) return;
      t0 = cyc;
      if (k > 0) check_val("byte_gap", 32'(t0 - t_prev), (k % 4 == 0) ? 32'd43 : 32'd41);
      if (k % 4 == 0) begin
        if (exp_addr_q.size() > 0) check_val("word_addr", addr_sel, exp_addr_q.pop_front());
        else check_val("addr_queue_empty", 32'd1, 32'd0);
      end
      check_val("busy_in_frame", {31'd0, busy_sel}, 32'd1);
      step(1);
      check_val("start_bit", {31'd0, tx_sel}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        step(CPB);
        b[i] = tx_sel;
      end
      step(CPB);
      check_val("stop_bit", {31'd0, tx_sel}, 32'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 8'hXX;
      check_val("rx_byte", {24'd0, b}, {24'd0, e});
      t_prev = t0;
    end
  endtask

  initial begin
    int s, b_busy, b_done, b_edges;
    logic ok;
    logic [31:0] reset_addr [4];
    reset_addr[0] = 32'h0000_0010;
    reset_addr[1] = 32'h0000_0000;
    reset_addr[2] = 32'hFFFF_FFF8;
    reset_addr[3] = 32'h0000_0000;
    rst = 1'b0;
    start_v = 4'd0;
    sel = 2'd0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      check_val("reset_tx",   {31'd0, tx_w[i]},   32'd1);
      check_val("reset_busy", {31'd0, busy_w[i]}, 32'd0);
      check_val("reset_done", {31'd0, done_w[i]}, 32'd0);
      check_val("reset_addr", addr_w[i], reset_addr[i]);
    end
    rst = 1'b1;
    step(3);

    // Single word
    sel = 2'd0;
    step(2);
    push_word(32'h0000_0010);
    b_busy = busy_cnt; b_done = done_cnt;
    pulse_start(0, s);
    recv_bytes(4);
    step(10);
    check_val("one_busy_len",  32'(busy_cnt - b_busy), 32'd166);
    check_val("one_done_cnt",  32'(done_cnt - b_done), 32'd1);
    check_val("one_done_time", 32'(done_cyc - s),      32'd167);
    check_val("one_addr_back", addr_sel, 32'h0000_0010);

    // Multi-word
    sel = 2'd1;
    step(2);
    push_word(32'h0); push_word(32'h4); push_word(32'h8);
    b_busy = busy_cnt; b_done = done_cnt;
    pulse_start(1, s);
    recv_bytes(12);
    step(10);
    check_val("multi_busy_len",  32'(busy_cnt - b_busy), 32'd498);
    check_val("multi_done_cnt",  32'(done_cnt - b_done), 32'd1);
    check_val("multi_done_time", 32'(done_cyc - s),      32'd499);
    check_val("multi_addr_back", addr_sel, 32'h0);

    // Start while busy
    sel = 2'd0;
    step(2);
    push_word(32'h0000_0010);
    b_busy = busy_cnt; b_done = done_cnt;
    pulse_start(0, s);
    fork
      recv_bytes(4);
      begin
        int s2;
        step(49);
        pulse_start(0, s2);
      end
    join
    step(10);
    check_val("rebusy_busy_len",  32'(busy_cnt - b_busy), 32'd166);
    check_val("rebusy_done_time", 32'(done_cyc - s),      32'd167);
    b_edges = tx_edges;
    step(300);
    check_val("rebusy_done_cnt", 32'(done_cnt - b_done), 32'd1);
    check_val("rebusy_no_tx",    32'(tx_edges - b_edges), 32'd0);

    // Address wrap
    sel = 2'd2;
    step(2);
    push_word(32'hFFFF_FFF8); push_word(32'hFFFF_FFFC); push_word(32'h0000_0000);
    b_done = done_cnt;
    pulse_start(2, s);
    recv_bytes(12);
    step(10);
    check_val("wrap_done_cnt",  32'(done_cnt - b_done), 32'd1);
    check_val("wrap_addr_back", addr_sel, 32'hFFFF_FFF8);

    // Mid-frame reset during data bits of byte 2
    sel = 2'd1;
    step(2);
    push_word(32'h0);
    pulse_start(1, s);
    recv_bytes(2);
    wait_tx_low(ok);
    step(10);
    rst = 1'b0;
    #1;
    check_val("rst_tx_high", {31'd0, tx_sel},   32'd1);
    check_val("rst_busy",    {31'd0, busy_sel}, 32'd0);
    check_val("rst_addr",    addr_sel, 32'h0);
    step(2);
    rst = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    step(2);
    b_edges = tx_edges; b_busy = busy_cnt; b_done = done_cnt;
    step(400);
    check_val("rst_no_tx_edges", 32'(tx_edges - b_edges), 32'd0);
    check_val("rst_no_busy",     32'(busy_cnt - b_busy),  32'd0);
    check_val("rst_no_done",     32'(done_cnt - b_done),  32'd0);

    // Empty dump
    sel = 2'd3;
    step(2);
    b_edges = tx_edges; b_busy = busy_cnt; b_done = done_cnt;
    pulse_start(3, s);
    step(30);
    check_val("empty_done_cnt",  32'(done_cnt - b_done),  32'd1);
    check_val("empty_done_time", 32'(done_cyc - s),       32'd1);
    check_val("empty_busy",      32'(busy_cnt - b_busy),  32'd0);
    check_val("empty_no_tx",     32'(tx_edges - b_edges), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
